// File: rtl/kbd_uart_rx.sv
// Keyboard/PC serial receiver: 8N1 frames into a single holding register
// with ready/overrun/frame-error status for a polled processor port.
module kbd_uart_rx #(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] data,
    output logic       ready,
    output logic       overrun,
    output logic       frame_err
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] C_ZERO = CW'(0);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_HALF = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] C_LAST = CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_rx_prev;
    logic [7:0]      r_data;
    logic            r_ready;
    logic            r_overrun;
    logic            r_frame_err;
    logic            w_fall;
    logic            w_commit;
    logic            w_stop_bad;

    // Edge detection works on the synchronized line and its one-cycle-old copy.
    assign w_fall = r_rx_prev & ~r_sync2;

    // Two-flop synchronizer plus edge-detect history; line idles high.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Frame state, bit timing counter, bit index and shift register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= C_ZERO;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic; the counter is always cleared before it could pass C_LAST.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_commit    = 1'b0;
        w_stop_bad  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = C_ZERO;
                if (w_fall) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (r_cnt == C_HALF) begin
                    w_cnt_nxt = C_ZERO;
                    w_idx_nxt = 3'd0;
                    if (!r_sync2) begin
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_DATA: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt   = C_ZERO;
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            S_STOP: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_nxt   = C_ZERO;
                    w_state_nxt = S_IDLE;
                    if (r_sync2) begin
                        w_commit = 1'b1;
                    end else begin
                        w_stop_bad = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = C_ZERO;
            end
        endcase
    end

    // Holding register and status; a commit takes priority over a read strobe.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_data      <= 8'h00;
            r_ready     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (w_commit) begin
            r_data      <= r_shift;
            r_ready     <= 1'b1;
            r_overrun   <= r_ready & ~rd;
            r_frame_err <= 1'b0;
        end else begin
            if (w_stop_bad) begin
                r_frame_err <= 1'b1;
            end
            if (rd) begin
                r_ready   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign ready     = r_ready;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_kbd_uart_rx.sv
// Self-checking bench for kbd_uart_rx at BAUD_DIV = 4: directed vector table,
// hand-written corner sequences and random frames against a frame-level model.
`timescale 1ns/1ps
module tb_kbd_uart_rx;

    localparam int BD    = 4;
    localparam int FRAME = 10 * BD;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic       overrun;
    logic       frame_err;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference state
    logic [7:0] m_data;
    logic       m_ready;
    logic       m_ovr;
    logic       m_fe;

    typedef struct {
        logic [7:0] b;
        bit         stop_ok;
        bit         rd_c;
        bit         rd_after;
        logic [7:0] e_data;
        bit         e_ready;
        bit         e_ovr;
        bit         e_fe;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    kbd_uart_rx #(.BAUD_DIV(BD)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .rd        (rd),
        .data      (data),
        .ready     (ready),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    // Line level at cycle idx of a frame: start, 8 data bits LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input bit stop_ok, input int idx);
        if (idx < BD) return 1'b0;
        else if (idx < 9 * BD) return b[(idx - BD) / BD];
        else return stop_ok;
    endfunction

    task automatic cyc(input logic rx_v, input logic rd_v);
        @(negedge clk);
        rx = rx_v;
        rd = rd_v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ed, input logic er,
                           input logic eo, input logic ef);
        chk1({tag, ".data"}, data, ed);
        chk1({tag, ".ready"}, {7'd0, ready}, {7'd0, er});
        chk1({tag, ".overrun"}, {7'd0, overrun}, {7'd0, eo});
        chk1({tag, ".frame_err"}, {7'd0, frame_err}, {7'd0, ef});
    endtask

    task automatic chk_model(input string tag);
        chk_out(tag, m_data, m_ready, m_ovr, m_fe);
    endtask

    // Whole frame plus one idle cycle; the stop sample happens in the next cycle.
    task automatic send_until_sample(input logic [7:0] b, input bit stop_ok);
        for (int i = 0; i < FRAME; i++) cyc(frame_bit(b, stop_ok, i), 1'b0);
        cyc(1'b1, 1'b0);
    endtask

    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit rd_c);
        if (stop_ok) begin
            m_ovr   = m_ready & ~rd_c;
            m_data  = b;
            m_ready = 1'b1;
            m_fe    = 1'b0;
        end else begin
            m_fe = 1'b1;
            if (rd_c) begin
                m_ready = 1'b0;
                m_ovr   = 1'b0;
            end
        end
    endtask

    task automatic model_rd();
        m_ready = 1'b0;
        m_ovr   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev_d;
        logic [7:0] b;
        bit         ok;
        bit         rdc;

        vecs[0] = '{8'h41, 1'b1, 1'b0, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h55, 1'b1, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hAA, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h0D, 1'b1, 1'b0, 1'b0, 8'h0D, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h7E, 1'b1, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h12, 1'b0, 1'b1, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h99, 1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0};

        rstn = 1'b0;
        repeat (3) cyc(1'b1, 1'b0);
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) cyc(1'b1, 1'b0);

        // Directed table
        prev_d = 8'h00;
        foreach (vecs[i]) begin
            send_until_sample(vecs[i].b, vecs[i].stop_ok);
            chk1($sformatf("vec%0d.pre_commit_data", i), data, prev_d);
            cyc(1'b1, vecs[i].rd_c);
            chk_out($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_ready,
                    vecs[i].e_ovr, vecs[i].e_fe);
            prev_d = vecs[i].e_data;
            if (vecs[i].rd_after) begin
                cyc(1'b1, 1'b1);
                chk_out($sformatf("vec%0d.after_rd", i), vecs[i].e_data, 1'b0, 1'b0, vecs[i].e_fe);
            end
        end
        m_data  = 8'h99;
        m_ready = 1'b1;
        m_ovr   = 1'b0;
        m_fe    = 1'b0;

        // One-cycle glitch while idle is rejected
        cyc(1'b0, 1'b0);
        repeat (12) cyc(1'b1, 1'b0);
        chk_model("glitch");
        send_until_sample(8'h5A, 1'b1);
        cyc(1'b1, 1'b1);
        model_frame(8'h5A, 1'b1, 1'b1);
        chk_model("after_glitch");

        // Random frames against the model
        for (int n = 0; n < 24; n++) begin
            b   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 5) != 0);
            rdc = ($urandom_range(0, 3) == 0);
            send_until_sample(b, ok);
            cyc(1'b1, rdc);
            model_frame(b, ok, rdc);
            chk_model($sformatf("rand%0d", n));
            if ($urandom_range(0, 2) == 0) begin
                cyc(1'b1, 1'b1);
                model_rd();
                chk_model($sformatf("rand%0d.rd", n));
            end
            repeat ($urandom_range(0, 3)) cyc(1'b1, 1'b0);
        end

        // Reset in the middle of bit 4 aborts the frame
        send_until_sample(8'hE7, 1'b1);
        cyc(1'b1, 1'b0);
        model_frame(8'hE7, 1'b1, 1'b0);
        chk_model("pre_reset");
        for (int i = 0; i < 5 * BD + 2; i++) cyc(frame_bit(8'hC3, 1'b1, i), 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) cyc(1'b1, 1'b0);
        chk_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        m_data  = 8'h00;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_fe    = 1'b0;
        repeat (FRAME) cyc(1'b1, 1'b0);
        chk_model("post_reset_idle");
        send_until_sample(8'h31, 1'b1);
        cyc(1'b1, 1'b0);
        model_frame(8'h31, 1'b1, 1'b0);
        chk_out("after_reset_31", 8'h31, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kbd_uart_rx.md
KBD_UART_RX -- requirements
Module: kbd_uart_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 104, clock cycles per serial bit (12 MHz / 115200).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial line from keyboard/PC; idle high.
REQ-005 SHALL have port rd  input  1  one-cycle read strobe from the processor keyboard port.
REQ-006 SHALL have port data  output  8  last received byte (holding register).
REQ-007 SHALL have port ready  output  1  holding register contains an unread byte.
REQ-008 SHALL have port overrun  output  1  a byte was overwritten before being read.
REQ-009 SHALL have port frame_err  output  1  last frame had its stop bit sampled low.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; both flops have reset value 1; all decisions use the synchronized value.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-012 IDLE -> START on a synchronized high-to-low transition of rx; the bit-timing counter clears to 0.
REQ-013 START: at count BAUD_DIV/2 (integer division), sample rx; low -> DATA with counter and bit index cleared; high -> IDLE (glitch rejected, no flags touched).
REQ-014 DATA: sample rx each time the counter reaches BAUD_DIV-1 (mid-bit), shift LSB first into an 8-bit shift register, and increment the 3-bit bit index; after the 8th sample -> STOP.
REQ-015 STOP: at the next mid-bit point, sample rx; high -> commit; low -> no commit, frame_err = 1, data and ready unchanged; either case -> IDLE.
REQ-016 Commit: data <= shift register, ready <= 1, frame_err <= 0; outputs are visible one clock after the stop-bit sample cycle.
REQ-017 Commit while ready = 1 and rd = 0: data overwritten, overrun <= 1.
REQ-018 rd = 1 with no commit in the same cycle: ready <= 0 and overrun <= 0 on that edge; data holds.
REQ-019 rd = 1 coinciding with a commit: the new byte wins; ready stays 1 and overrun <= 0.
REQ-020 rd = 1 while ready = 0: no effect.
REQ-021 IDLE re-arms immediately; a start edge during the stop bit's second half is detected after returning to IDLE.
REQ-022 The bit-timing counter SHALL be ceil(log2(BAUD_DIV)) bits wide and never wrap past BAUD_DIV-1.

Reset
REQ-023 While rstn = 0 at a rising clk edge, SHALL force: state IDLE; counter 0; bit index 0; shift register 0x00; data 0x00; ready 0; overrun 0; frame_err 0; synchronizer flops 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no commit; reception restarts only on a fresh start edge after rstn = 1.

Verification (BAUD_DIV = 4)
REQ-025 Send 0x41 (start, bits 1,0,0,0,0,0,1,0, stop high) -> ready = 1 and data = 0x41 one cycle after the stop sample; overrun = 0, frame_err = 0.
REQ-026 Send 0x55 then 0xAA with no rd -> data = 0xAA, ready = 1, overrun = 1; pulse rd -> ready = 0, overrun = 0, data = 0xAA.
REQ-027 rx low for 1 cycle while idle -> START samples high, returns to IDLE; ready, data, and flags unchanged.
REQ-028 Send 0x3C with stop bit low -> frame_err = 1, ready = 0, data keeps its previous value; a following valid 0x0D -> data = 0x0D, frame_err = 0.
REQ-029 Assert rd in the exact commit cycle of 0x7E while ready = 1 -> ready = 1, data = 0x7E, overrun = 0.
REQ-030 Drop rstn during bit 4 of a frame, release, then send 0x31 -> after reset all outputs are 0; only 0x31 is received, with no overrun.
